// File: rtl/axi_burst_master.sv
// Single-outstanding AXI3 INCR burst master: one command becomes one write or read burst.
// Optional watchdog built when AXI_MASTER_TIMEOUT_EN is defined.
module axi_burst_master #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [3:0]               cmd_id,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [3:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [31:0]              cmd_wdata,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               awid,
    output logic [ADDRESS_WIDTH-1:0] awaddr,
    output logic [3:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [3:0]               wid,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    input  logic                     bvalid,
    output logic                     bready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [3:0]               arid,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_last,
    output logic                     done,
    output logic [1:0]               done_status
);

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR} state_e;

    state_e                   state_q, state_d;
    logic                     init_q;
    logic [3:0]               id_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [3:0]               len_q;
    logic [2:0]               size_q;
    logic [31:0]              seed_q;
    logic [3:0]               beat_q;
    logic [1:0]               status_q;
    logic                     done_q;
    logic [1:0]               done_status_q;
    logic                     rsp_valid_q;
    logic [31:0]              rsp_data_q;
    logic                     rsp_last_q;

    logic       cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic       timeout;
    logic [1:0] beat_lo;
    logic [1:0] r_worst, r_next;
    logic       unused_cfg;

    assign unused_cfg = (DATA_WIDTH != 32);

    assign cmd_ready = init_q && (state_q == StIdle) && !done_q;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign b_hs      = bvalid && bready;
    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;

    // Only the low two address bits of the current beat matter for byte lanes.
    assign beat_lo = addr_q[1:0] + (beat_q[1:0] << size_q[1:0]);

    assign awvalid = (state_q == StAw);
    assign awid    = awvalid ? id_q : '0;
    assign awaddr  = awvalid ? addr_q : '0;
    assign awlen   = awvalid ? len_q : '0;
    assign awsize  = awvalid ? size_q : '0;
    assign awburst = awvalid ? 2'b01 : 2'b00;

    assign arvalid = (state_q == StAr);
    assign arid    = arvalid ? id_q : '0;
    assign araddr  = arvalid ? addr_q : '0;
    assign arlen   = arvalid ? len_q : '0;
    assign arsize  = arvalid ? size_q : '0;
    assign arburst = arvalid ? 2'b01 : 2'b00;

    assign wvalid = (state_q == StW);
    assign wid    = wvalid ? id_q : '0;
    assign wdata  = wvalid ? (seed_q + {28'b0, beat_q}) : '0;
    assign wlast  = wvalid && (beat_q == len_q);

    always_comb begin
        wstrb = 4'b0000;
        if (wvalid) begin
            case (size_q)
                3'd0:    wstrb = 4'b0001 << beat_lo;
                3'd1:    wstrb = 4'b0011 << {beat_lo[1], 1'b0};
                default: wstrb = 4'b1111;
            endcase
        end
    end

    assign bready = (state_q == StB);
    assign rready = (state_q == StR);

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_last    = rsp_valid_q && rsp_last_q;
    assign done        = done_q;
    assign done_status = done_q ? done_status_q : 2'b00;

    assign r_worst = (rresp > status_q) ? rresp : status_q;
    assign r_next  = ((rid != id_q) || (rlast && (beat_q != len_q))) ? 2'b10 : r_worst;

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [31:0] wdog_q;
    logic        any_hs;

    assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign timeout = (state_q != StIdle) && !any_hs && (wdog_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wdog_q <= '0;
        end else if ((state_q == StIdle) || any_hs) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_hs && (cmd_size <= 3'd2)) state_d = cmd_write ? StAw : StAr;
            StAw:   if (aw_hs) state_d = StW;
            StW:    if (w_hs && wlast) state_d = StB;
            StB:    if (b_hs) state_d = StIdle;
            StAr:   if (ar_hs) state_d = StR;
            StR:    if (r_hs && rlast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (timeout) state_d = StIdle;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q       <= StIdle;
            init_q        <= 1'b0;
            id_q          <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            seed_q        <= '0;
            beat_q        <= '0;
            status_q      <= '0;
            done_q        <= 1'b0;
            done_status_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            if (cmd_hs) begin
                id_q     <= cmd_id;
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                size_q   <= cmd_size;
                seed_q   <= cmd_wdata;
                beat_q   <= '0;
                status_q <= 2'b00;
                // Illegal size: no bus traffic, just report an error.
                if (cmd_size > 3'd2) begin
                    done_q        <= 1'b1;
                    done_status_q <= 2'b10;
                end
            end
            if (w_hs && !wlast) beat_q <= beat_q + 4'd1;
            if (b_hs) begin
                done_q        <= 1'b1;
                done_status_q <= (bid != id_q) ? 2'b10 : bresp;
            end
            if (r_hs) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rdata;
                rsp_last_q  <= rlast;
                beat_q      <= beat_q + 4'd1;
                status_q    <= r_next;
                if (rlast) begin
                    done_q        <= 1'b1;
                    done_status_q <= r_next;
                end
            end
            if (timeout) begin
                done_q        <= 1'b1;
                done_status_q <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench plays the AXI slave and checks each cycle.
module tb_axi_burst_master;

    logic        aclk = 1'b0;
    logic        arst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id, cmd_len;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        awvalid, awready;
    logic [3:0]  awid, awlen;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [3:0]  arid, arlen;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rsp_valid, rsp_last, done;
    logic [31:0] rsp_data;
    logic [1:0]  done_status;

    int n_checks = 0;
    int n_errors = 0;
    int w_hs_cnt = 0;

    always #5 aclk = ~aclk;

    axi_burst_master dut (
        .aclk(aclk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .done(done), .done_status(done_status)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [31:0] seed);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_wdata = seed;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic count_w();
        if (wvalid === 1'b1 && wready === 1'b1) w_hs_cnt++;
    endtask

    task automatic r_beat(input logic [31:0] d, input logic [3:0] id, input logic last);
        rvalid = 1'b1;
        rdata  = d;
        rid    = id;
        rresp  = 2'b00;
        rlast  = last;
    endtask

    initial begin
        arst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0;
        cmd_len = '0; cmd_size = '0; cmd_wdata = '0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bid = '0; bresp = '0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_done", {done, rsp_valid, wlast}, 0);
        check("rst_wstrb", wstrb, 0);
        arst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Write len 1 size 1 at 22
        send_cmd(1'b1, 4'd1, 32'd22, 4'd1, 3'd1, 32'h3048);
        check("wr_aw_valid", awvalid, 1);
        check("wr_aw_fields", {awid, awaddr, awlen, awsize, awburst}, {4'd1, 32'd22, 4'd1, 3'd1, 2'b01});
        check("wr_cmd_ready_busy", cmd_ready, 0);
        tick();
        check("wr_b0", {wvalid, wid, wdata, wstrb, wlast}, {1'b1, 4'd1, 32'h3048, 4'b1100, 1'b0});
        tick();
        check("wr_b1", {wvalid, wdata, wstrb, wlast}, {1'b1, 32'h3049, 4'b0011, 1'b1});
        tick();
        check("wr_bready", {bready, wvalid}, {1'b1, 1'b0});
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check("wr_done", {done, done_status, cmd_ready}, {1'b1, 2'b00, 1'b0});
        tick();
        check("wr_after_done", {done, cmd_ready}, {1'b0, 1'b1});

        // Read len 3 size 0 at 15
        send_cmd(1'b0, 4'd2, 32'd15, 4'd3, 3'd0, 32'h0);
        check("rd_ar_fields", {arvalid, arid, araddr, arlen, arsize, arburst},
              {1'b1, 4'd2, 32'd15, 4'd3, 3'd0, 2'b01});
        tick();
        check("rd_rready", rready, 1);
        r_beat(32'h34, 4'd2, 1'b0);
        tick();
        check("rd_beat0", {rsp_valid, rsp_data, rsp_last, done}, {1'b1, 32'h34, 1'b0, 1'b0});
        r_beat(32'hAB, 4'd2, 1'b0);
        tick();
        check("rd_beat1", {rsp_valid, rsp_data, rsp_last, done}, {1'b1, 32'hAB, 1'b0, 1'b0});
        r_beat(32'h01, 4'd2, 1'b0);
        tick();
        check("rd_beat2", {rsp_valid, rsp_data, rsp_last, done}, {1'b1, 32'h01, 1'b0, 1'b0});
        r_beat(32'h02, 4'd2, 1'b1);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        check("rd_beat3", {rsp_valid, rsp_data, rsp_last}, {1'b1, 32'h02, 1'b1});
        check("rd_done", {done, done_status}, {1'b1, 2'b00});
        tick();
        check("rd_after", {rsp_valid, done, cmd_ready}, {1'b0, 1'b0, 1'b1});

        // wready stall on beat 0, then bid mismatch
        wready = 1'b0;
        w_hs_cnt = 0;
        send_cmd(1'b1, 4'd4, 32'h100, 4'd1, 3'd2, 32'hA0);
        check("st_aw", {awvalid, awaddr}, {1'b1, 32'h100});
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("st_hold%0d", i), {wvalid, wdata, wstrb, wlast},
                  {1'b1, 32'hA0, 4'hF, 1'b0});
            count_w();
            tick();
        end
        wready = 1'b1;
        check("st_b0", {wvalid, wdata, wstrb}, {1'b1, 32'hA0, 4'hF});
        count_w();
        tick();
        check("st_b1", {wvalid, wdata, wlast}, {1'b1, 32'hA1, 1'b1});
        count_w();
        tick();
        count_w();
        check("st_hs_count", w_hs_cnt, 2);
        bvalid = 1'b1; bid = 4'd5; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check("bid_mismatch", {done, done_status}, {1'b1, 2'b10});
        tick();

        // Early rlast on read len 2
        send_cmd(1'b0, 4'd6, 32'h40, 4'd2, 3'd2, 32'h0);
        tick();
        r_beat(32'h11, 4'd6, 1'b0);
        tick();
        r_beat(32'h22, 4'd6, 1'b1);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        check("early_rlast", {rsp_last, done, done_status}, {1'b1, 1'b1, 2'b10});
        tick();

        // Reset during write beat 1
        send_cmd(1'b1, 4'd7, 32'h0, 4'd3, 3'd2, 32'h500);
        tick();
        check("rs_b0", {wvalid, wdata}, {1'b1, 32'h500});
        tick();
        check("rs_b1", {wvalid, wdata}, {1'b1, 32'h501});
        arst = 1'b1;
        #1;
        check("rs_async_drop", {wvalid, awvalid, done}, 0);
        tick();
        arst = 1'b0;
        check("rs_no_done", done, 0);
        tick();
        check("rs_ready", {cmd_ready, done}, {1'b1, 1'b0});
        send_cmd(1'b1, 4'd8, 32'h8, 4'd0, 3'd0, 32'h77);
        check("rs_new_aw", {awvalid, awid, awaddr, awlen}, {1'b1, 4'd8, 32'h8, 4'd0});
        tick();
        check("rs_new_b0", {wvalid, wdata, wstrb, wlast}, {1'b1, 32'h77, 4'b0001, 1'b1});
        tick();
        bvalid = 1'b1; bid = 4'd8; bresp = 2'b01;
        tick();
        bvalid = 1'b0;
        check("rs_new_done", {done, done_status}, {1'b1, 2'b01});
        tick();

        // Illegal size
        send_cmd(1'b1, 4'd9, 32'h0, 4'd0, 3'd3, 32'h0);
        check("ill_done", {awvalid, arvalid, done, done_status}, {1'b0, 1'b0, 1'b1, 2'b10});
        tick();
        check("ill_after", {awvalid, done, cmd_ready}, {1'b0, 1'b0, 1'b1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
